// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared declarations for the memory request front end.
//   mux_state_e : issue FSM states (IDLE accepts a grant, HOLD skips the
//                 single cycle in which the arbiter's registered grant is stale)
//   sel_width() : width of a port index for a given port count
// The tag and request records depend on module parameters, so each module
// declares them locally from these widths.
package mem_req_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } mux_state_e;

  function automatic int sel_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/mem_rsp_tag_pipe.sv
// mem_rsp_tag_pipe: DEPTH-deep shift register of read tags {vld, sel}.
// The tag vld bit is the MSB.
//   clk, rst : clock and synchronous active-high reset (clears all stages)
//   tag_in   : tag entering stage 0 every cycle
//   pre_vld  : vld bit of stage DEPTH-2 (the stage about to become the last)
//   tag_out  : stage DEPTH-1, the tag whose response is currently presented
import mem_req_pkg::*;

module mem_rsp_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] tag_in,
  output logic             pre_vld,
  output logic [TAG_W-1:0] tag_out
);

  logic [TAG_W-1:0] stage_reg [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) stage_reg[gi] <= '0;
          else     stage_reg[gi] <= tag_in;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (rst) stage_reg[gi] <= '0;
          else     stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign pre_vld = stage_reg[DEPTH-2][TAG_W-1];
  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/mem_req_mux.sv
// mem_req_mux: shared-memory request front end ahead of a round-robin arbiter.
// Holds one request per client port, presents the pending set to the arbiter,
// issues the granted request to a single-port SRAM and returns read data to
// the originating port through a latency-matched tag pipeline.
//   clk, rst                          : clock, synchronous active-high reset
//   req_valid/ready/we/addr/wdata     : per-port request handshake and payload
//   rsp_valid (one-hot), rsp_rdata    : read response strobe and data
//   arb_request                       : pending vector to the arbiter
//   arb_grant/arb_select/arb_active   : registered arbiter outputs
//   mem_en/we/addr/wdata, mem_rdata   : SRAM port (read data RD_LAT after mem_en)
import mem_req_pkg::*;

module mem_req_mux #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int SEL_WIDTH = sel_width(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_valid,
  output logic [NUM_PORTS-1:0]        req_ready,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [NUM_PORTS-1:0]        arb_request,
  input  logic [NUM_PORTS-1:0]        arb_grant,
  input  logic [SEL_WIDTH-1:0]        arb_select,
  input  logic                        arb_active,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int TAG_W = SEL_WIDTH + 1;
  localparam logic [SEL_WIDTH:0] NUM_PORTS_W = (SEL_WIDTH + 1)'(NUM_PORTS);

  typedef struct packed {
    logic                 vld;
    logic [SEL_WIDTH-1:0] sel;
  } tag_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Per-port holding registers
  logic [NUM_PORTS-1:0] pend_reg;
  logic [NUM_PORTS-1:0] pend_next;
  logic [NUM_PORTS-1:0] capture;
  logic [NUM_PORTS-1:0] clear;
  req_t                 hold_reg [NUM_PORTS];

  // Issue FSM and SRAM port registers
  mux_state_e           state_reg;
  mux_state_e           state_next;
  logic                 accept_grant;
  logic                 sel_in_range;
  logic                 fire;
  logic                 mem_en_reg;
  logic                 mem_we_reg;
  logic [ADDR_W-1:0]    mem_addr_reg;
  logic [DATA_W-1:0]    mem_wdata_reg;
  logic [SEL_WIDTH-1:0] issue_sel_reg;

  // Response path
  tag_t                 tag_in;
  tag_t                 tag_out;
  logic                 pre_vld;
  logic [DATA_W-1:0]    rsp_rdata_reg;

  // ---------------------------------------------------------------------------
  // Request capture. Ready depends only on pend, never on req_valid.
  // ---------------------------------------------------------------------------
  assign req_ready   = ~pend_reg;
  assign arb_request = pend_reg;
  assign capture     = req_valid & ~pend_reg;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_clear
      assign clear[gi] = fire & (arb_select == SEL_WIDTH'(gi));
    end
  endgenerate

  // capture needs pend=0 and clear needs pend=1, so they never collide.
  assign pend_next = (pend_reg & ~clear) | capture;

  always_ff @(posedge clk) begin
    if (rst) pend_reg <= '0;
    else     pend_reg <= pend_next;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (capture[i]) begin
        hold_reg[i] <= '{we:    req_we[i],
                         addr:  req_addr[i*ADDR_W +: ADDR_W],
                         wdata: req_wdata[i*DATA_W +: DATA_W]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM. After an issue the arbiter's registered grant still points at
  // the port just served for one cycle; HOLD sits out that cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fire) state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept_grant = (state_reg == IDLE);
  end

  assign sel_in_range = ({1'b0, arb_select} < NUM_PORTS_W);

  // A grant only counts if the selected port still holds a request; a stale
  // grant to an empty port is ignored.
  assign fire = accept_grant & arb_active & sel_in_range &
                arb_grant[arb_select] & pend_reg[arb_select];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      issue_sel_reg <= '0;
    end else begin
      mem_en_reg <= fire;
      if (fire) begin
        mem_we_reg    <= hold_reg[arb_select].we;
        mem_addr_reg  <= hold_reg[arb_select].addr;
        mem_wdata_reg <= hold_reg[arb_select].wdata;
        issue_sel_reg <= arb_select;
      end
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  // ---------------------------------------------------------------------------
  // Read responses. Stage k of the tag pipe is visible k+1 cycles after mem_en,
  // so stage RD_LAT-1 lines up with valid mem_rdata and the last stage lines up
  // with the registered rsp_rdata.
  // ---------------------------------------------------------------------------
  assign tag_in = '{vld: mem_en_reg & ~mem_we_reg, sel: issue_sel_reg};

  mem_rsp_tag_pipe #(
    .DEPTH (RD_LAT + 1),
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .pre_vld (pre_vld),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk) begin
    if (rst)          rsp_rdata_reg <= '0;
    else if (pre_vld) rsp_rdata_reg <= mem_rdata;
  end

  assign rsp_rdata = rsp_rdata_reg;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
      assign rsp_valid[gi] = tag_out.vld & (tag_out.sel == SEL_WIDTH'(gi));
    end
  endgenerate

endmodule
